coin_detect: RTL and testbench
==============================

COIN_DETECT -- requirements
Module: coin_detect

Interface
REQ-001 Parameter: CNT_MAX, 20'd999_999, debounce length in clk cycles (20 ms at 50 MHz); the bench overrides it to 4.
REQ-002 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: coin_half_n  input  1  raw 0.5-yuan slot sensor, active-low, asynchronous to clk, bouncy.
REQ-005 Port: coin_one_n  input  1  raw 1-yuan slot sensor, active-low, asynchronous to clk, bouncy.
REQ-006 Port: pi_money_half  output  1  one-cycle pulse per accepted 0.5-yuan coin, to the vending FSM.
REQ-007 Port: pi_money_one  output  1  one-cycle pulse per accepted 1-yuan coin, to the vending FSM.
REQ-008 Port: coin_busy  output  1  high while a half pulse is deferred (see REQ-016).

Function
REQ-009 Each raw input SHALL pass through a two-flop synchronizer; reset value of both flops is 1.
REQ-010 Each channel SHALL have a debounce counter of width clog2(CNT_MAX+1) that clears whenever the synchronized level is 1.
REQ-011 The counter SHALL increment by 1 per cycle while the synchronized level is 0, and saturate (hold) at CNT_MAX.
REQ-012 A channel SHALL raise an internal press flag for exactly one cycle: the cycle where its counter equals CNT_MAX-1 and the synchronized level is 0.
REQ-013 Latency: with the raw input stable low from clk edge 1, the output pulse SHALL be high for the cycle following edge CNT_MAX+2.
REQ-014 One physical press (low held any length beyond CNT_MAX) SHALL produce exactly one pulse; a new pulse needs the synchronized level to return to 1 for at least one cycle.
REQ-015 A low glitch shorter than CNT_MAX synchronized cycles SHALL produce no pulse.
REQ-016 pi_money_half and pi_money_one SHALL never be high in the same cycle. If both flags fire in the same cycle, pi_money_one pulses first and the half event is held in a pending register, with coin_busy=1.
REQ-017 A pending half event SHALL be emitted on the next cycle in which the one-flag is not firing; coin_busy clears in that same cycle.
REQ-018 Outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-019 Pulses SHALL be exactly one clk cycle wide.

Reset
REQ-020 On rst_n=0, the following SHALL clear immediately, regardless of clk: pi_money_half=0, pi_money_one=0, coin_busy=0, counters=0, pending=0, synchronizers=1.
REQ-021 Reset asserted mid-debounce or with an event pending SHALL discard that event; no pulse is emitted after reset release unless a fresh, full debounce completes.
REQ-022 After rst_n deasserts, an input held low throughout reset SHALL be debounced from scratch, producing one pulse at the REQ-013 latency.

Configuration
REQ-023 Macro COIN_DETECT_CNT_EN SHALL control the feature below; it is compiled in when defined.
REQ-024 When defined, the block SHALL add port cnt_clr (input, 1 bit, synchronous clear) and port coin_total (output, 8 bits).
REQ-025 coin_total SHALL hold the accepted value in 0.5-yuan units: +1 per pi_money_half pulse, +2 per pi_money_one pulse.
REQ-026 coin_total SHALL saturate at 255.
REQ-027 cnt_clr SHALL win over a same-cycle increment.
REQ-028 coin_total SHALL reset to 0.
REQ-029 When COIN_DETECT_CNT_EN is not defined, the cnt_clr and coin_total ports and their logic SHALL be absent; all other behaviour is unchanged.

Verification (CNT_MAX=4)
REQ-030 Scenario: coin_half_n low from edge 1, held 20 cycles -> a single pi_money_half pulse after edge 6; pi_money_one stays 0.
REQ-031 Scenario: coin_one_n low for 3 cycles, high for 1, then low for 3, repeated 5 times -> no output pulse.
REQ-032 Scenario: both inputs fall on the same edge and are held -> pi_money_one pulses after edge 6, pi_money_half after edge 7, coin_busy=1 for exactly one cycle.
REQ-033 Scenario: coin_one_n low; rst_n pulsed low after edge 4 -> no pulse; after release, one pulse 6 cycles after the first sampling edge.
REQ-034 Scenario: 10 alternating presses (half, one, half, ...) separated by 10-cycle high gaps -> 5 pulses on each output and never both high.
REQ-035 Scenario (COIN_DETECT_CNT_EN): 130 pi_money_one events -> coin_total=255; then cnt_clr=1 for one cycle -> coin_total=0.

Source files
------------

// File: rtl/coin_detect.sv
// Coin slot front end for the vending controller.
// Two active-low, bouncy slot sensors are synchronised and debounced.
// Each accepted coin produces a single one-cycle pulse. A 1-yuan event that
// coincides with a 0.5-yuan event goes out first. The half event waits in a
// pending register and coin_busy is high while it waits.
// Optional feature: define COIN_DETECT_CNT_EN to add cnt_clr and coin_total.
// coin_total is a saturating count of accepted value in 0.5-yuan units.
module coin_detect #(
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_half_n,
    input  logic       coin_one_n,
`ifdef COIN_DETECT_CNT_EN
    input  logic       cnt_clr,
    output logic [7:0] coin_total,
`endif
    output logic       pi_money_half,
    output logic       pi_money_one,
    output logic       coin_busy
);

    localparam int CW = $clog2(int'(CNT_MAX) + 1);
    localparam logic [CW-1:0] CNT_TOP = CNT_MAX[CW-1:0];
    localparam logic [CW-1:0] CNT_PRE = CW'(CNT_MAX - 20'd1);

    // Channel 0 is the 0.5-yuan slot and channel 1 is the 1-yuan slot.
    logic [1:0] raw_n;
    logic [1:0] press_flag;

    assign raw_n = {coin_one_n, coin_half_n};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic          sync1_q, sync1_d;
            logic          sync2_q, sync2_d;
            logic [CW-1:0] cnt_q, cnt_d;

            // The synchroniser shifts in the raw level.
            // The counter runs while the synchronised level is low and holds at CNT_MAX.
            always_comb begin
                sync1_d = raw_n[gi];
                sync2_d = sync1_q;
                cnt_d   = cnt_q;
                if (sync2_q) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_TOP) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Registers for the synchroniser and the debounce counter. Idle state is "released".
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    cnt_q   <= cnt_d;
                end
            end

            // The counter passes CNT_MAX-1 only once per press, so this flag is a single cycle.
            assign press_flag[gi] = (cnt_q == CNT_PRE) && !sync2_q;
        end
    endgenerate

    logic half_q, half_d;
    logic one_q, one_d;
    logic pending_q, pending_d;
    logic busy_q, busy_d;
    logic half_src;

    // Arbitration: the 1-yuan event always wins. A half event that cannot go out is parked.
    always_comb begin
        half_src  = press_flag[0] || pending_q;
        one_d     = press_flag[1];
        half_d    = 1'b0;
        pending_d = 1'b0;
        if (press_flag[1]) begin
            pending_d = half_src;
        end else begin
            half_d = half_src;
        end
        busy_d = pending_d;
    end

    // Output and pending registers. No combinational path reaches the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q    <= 1'b0;
            one_q     <= 1'b0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            half_q    <= half_d;
            one_q     <= one_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
        end
    end

    assign pi_money_half = half_q;
    assign pi_money_one  = one_q;
    assign coin_busy     = busy_q;

`ifdef COIN_DETECT_CNT_EN
    logic [7:0] total_q, total_d;
    logic [8:0] total_sum;

    // Accumulate the emitted pulses: +1 for half, +2 for one.
    // The total saturates at 255. A clear wins over an increment in the same cycle.
    always_comb begin
        total_sum = {1'b0, total_q} + {7'b0, one_q, half_q};
        total_d   = total_sum[8] ? 8'hFF : total_sum[7:0];
        if (cnt_clr) begin
            total_d = 8'd0;
        end
    end

    // Running total register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= 8'd0;
        end else begin
            total_q <= total_d;
        end
    end

    assign coin_total = total_q;
`endif

endmodule

// File: tb/tb_coin_detect.sv
// Scoreboard bench for coin_detect with CNT_MAX = 4.
// Stimulus pushes expected (cycle, kind) events.
// A monitor on the falling edge pops one event for each output it sees high.
module tb_coin_detect;

    localparam int K_HALF = 0;
    localparam int K_ONE  = 1;
    localparam int K_BUSY = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic coin_half_n = 1'b1;
    logic coin_one_n = 1'b1;
    logic pi_money_half, pi_money_one, coin_busy;
`ifdef COIN_DETECT_CNT_EN
    logic       cnt_clr = 1'b0;
    logic [7:0] coin_total;
`endif

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  tot = 0;

    coin_detect #(.CNT_MAX(20'd4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_half_n  (coin_half_n),
        .coin_one_n   (coin_one_n),
`ifdef COIN_DETECT_CNT_EN
        .cnt_clr      (cnt_clr),
        .coin_total   (coin_total),
`endif
        .pi_money_half(pi_money_half),
        .pi_money_one (pi_money_one),
        .coin_busy    (coin_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
        if (k == K_HALF) tot = (tot + 1 > 255) ? 255 : tot + 1;
        if (k == K_ONE)  tot = (tot + 2 > 255) ? 255 : tot + 2;
    endtask

    task automatic see(input int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_cycle", cyc, e.cyc);
            $display("event kind=%0d cycle=%0d (expected kind=%0d cycle=%0d)", k, cyc, e.kind, e.cyc);
        end
    endtask

    // Monitor: compare every high output against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pi_money_half && pi_money_one) chk("both_high", 1, 0);
            if (pi_money_one)  see(K_ONE);
            if (pi_money_half) see(K_HALF);
            if (coin_busy)     see(K_BUSY);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_half"}, int'(pi_money_half), 0);
        chk({tag, "_one"},  int'(pi_money_one), 0);
        chk({tag, "_busy"}, int'(coin_busy), 0);
    endtask

    initial begin
        int c;
        int r;
        #1;
        chk_zero_outputs("reset");
`ifdef COIN_DETECT_CNT_EN
        chk("reset_total", int'(coin_total), 0);
`endif
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // A single long half press gives one pulse after edge 6.
        c = cyc;
        coin_half_n = 1'b0;
        push(c + 6, K_HALF);
        tick(20);
        coin_half_n = 1'b1;
        tick(10);

        // Short glitches on the one slot give no pulse.
        repeat (5) begin
            coin_one_n = 1'b0;
            tick(3);
            coin_one_n = 1'b1;
            tick(1);
        end
        tick(10);

        // Both slots fall together: one first, busy for one cycle, then half.
        c = cyc;
        coin_half_n = 1'b0;
        coin_one_n  = 1'b0;
        push(c + 6, K_ONE);
        push(c + 6, K_BUSY);
        push(c + 7, K_HALF);
        tick(15);
        coin_half_n = 1'b1;
        coin_one_n  = 1'b1;
        tick(10);

        // Reset arrives mid-debounce. The press is discarded and debounced again after release.
        c = cyc;
        coin_one_n = 1'b0;
        tick(4);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        tot = 0;
        #1;
        chk_zero_outputs("async_reset");
        tick(3);
        r = cyc;
        rst_n = 1'b1;
        push(r + 6, K_ONE);
        tick(15);
        coin_one_n = 1'b1;
        tick(10);

        // Reset arrives while a half event is pending. The pending half is dropped.
        c = cyc;
        coin_half_n = 1'b0;
        coin_one_n  = 1'b0;
        push(c + 6, K_ONE);
        push(c + 6, K_BUSY);
        tick(6);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        tot = 0;
        #1;
        chk_zero_outputs("pending_reset");
        tick(3);
        r = cyc;
        rst_n = 1'b1;
        push(r + 6, K_ONE);
        push(r + 6, K_BUSY);
        push(r + 7, K_HALF);
        tick(15);
        coin_half_n = 1'b1;
        coin_one_n  = 1'b1;
        tick(10);

        // Ten alternating presses separated by high gaps.
        for (int i = 0; i < 10; i++) begin
            c = cyc;
            if (i % 2 == 0) begin
                coin_half_n = 1'b0;
                push(c + 6, K_HALF);
            end else begin
                coin_one_n = 1'b0;
                push(c + 6, K_ONE);
            end
            tick(6);
            coin_half_n = 1'b1;
            coin_one_n  = 1'b1;
            tick(10);
        end

`ifdef COIN_DETECT_CNT_EN
        chk("total_mid", int'(coin_total), tot);
        for (int i = 0; i < 130; i++) begin
            c = cyc;
            coin_one_n = 1'b0;
            push(c + 6, K_ONE);
            tick(6);
            coin_one_n = 1'b1;
            tick(4);
        end
        tick(5);
        chk("total_saturated", int'(coin_total), 255);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("total_cleared", int'(coin_total), 0);
`endif

        tick(10);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
